// File: rtl/alu_ctrl_mdu_pkg.sv
// alu_ctrl_mdu_pkg: ALUOp/funct encodings, ALUControl codes and MDU state type
package alu_ctrl_mdu_pkg;
  localparam logic [1:0] OP_MEM = 2'b00, OP_BEQ = 2'b01, OP_R = 2'b10, OP_ORI = 2'b11;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010,
    F_SUBU = 6'b100011, F_AND = 6'b100100, F_OR = 6'b100101, F_XOR = 6'b100110,
    F_NOR = 6'b100111, F_SLT = 6'b101010, F_SLTU = 6'b101011, F_SLL = 6'b000000,
    F_SRL = 6'b000010, F_SRA = 6'b000011, F_MFHI = 6'b010000, F_MTHI = 6'b010001,
    F_MFLO = 6'b010010, F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001,
    F_DIV = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_XOR = 4'b0011,
    C_NOR = 4'b0100, C_SLL = 4'b0101, C_SUB = 4'b0110, C_SLT = 4'b0111, C_SRL = 4'b1000,
    C_SRA = 4'b1001, C_SLTU = 4'b1010, C_MDRD = 4'b1011, C_NOP = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} mdu_state_t;
  // HI/LO access is 0100xx, mult/div is 0110xx
  function automatic logic is_md(input logic [5:0] f);
    return f[5:4] == 2'b01 && f[2] == 1'b0;
  endfunction
endpackage

// File: rtl/alu_ctrl_mdu_if.sv
// alu_ctrl_mdu_if: EX-stage bus between pipeline and ALU control / MDU
interface alu_ctrl_mdu_if #(parameter int WIDTH = 32);
  logic             valid_in, flush, illegal, stall, busy, done;
  logic [1:0]       ALUOp;
  logic [5:0]       funct;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] src_a, src_b, md_rdata;
  modport master(output valid_in, flush, ALUOp, funct, src_a, src_b,
                 input ALUControl, illegal, md_rdata, stall, busy, done);
  modport slave(input valid_in, flush, ALUOp, funct, src_a, src_b,
                output ALUControl, illegal, md_rdata, stall, busy, done);
endinterface

// File: rtl/alu_ctrl_mdu_iter.sv
// alu_ctrl_mdu_iter: iterative shift-add multiply / restoring divide with sign fix-up
module alu_ctrl_mdu_iter
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_div,
  input  logic             i_sgn,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wr,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  mdu_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p, w_step, w_res;
  logic [WIDTH-1:0]   r_m, r_a, w_ma, w_mb, w_hm, w_lm;
  logic [WIDTH:0]     w_sum, w_t, w_diff;
  logic               r_div, r_nq, r_nr, r_dz, r_done;
  assign w_ma   = (i_sgn & i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mb   = (i_sgn & i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_t    = r_p[2*WIDTH-1:WIDTH-1];
  assign w_diff = w_t - {1'b0, r_m};
  // r_p holds {acc, multiplier} for mult and {remainder, dividend/quotient} for div
  assign w_step = !r_div ? {w_sum, r_p[WIDTH-1:1]}
                : w_diff[WIDTH] ? {w_t[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                : {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
  assign w_hm   = r_p[2*WIDTH-1:WIDTH];
  assign w_lm   = r_p[WIDTH-1:0];
  assign w_res  = r_dz ? {r_a, {WIDTH{1'b1}}}
                : r_div ? {r_nr ? -w_hm : w_hm, r_nq ? -w_lm : w_lm}
                : r_nq ? -r_p : r_p;
  assign o_hi   = w_res[2*WIDTH-1:WIDTH];
  assign o_lo   = w_res[WIDTH-1:0];
  assign o_wr   = (r_state == S_FIX) & ~i_abort;
  assign o_busy = r_state != S_IDLE;
  assign o_done = r_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_a     <= '0;
      r_div   <= 1'b0;
      r_nq    <= 1'b0;
      r_nr    <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= o_wr;
      if (r_state != S_IDLE && i_abort) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (r_state == S_IDLE && i_start) begin
        r_state <= S_ITER;
        r_cnt   <= '0;
        r_p     <= {{WIDTH{1'b0}}, w_ma};
        r_m     <= w_mb;
        r_a     <= i_a;
        r_div   <= i_div;
        r_dz    <= i_div & (i_b == '0);
        r_nq    <= i_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        r_nr    <= i_sgn & i_a[WIDTH-1];
      end else if (r_state == S_ITER) begin
        r_p   <= w_step;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          r_state <= S_FIX;
          r_cnt   <= '0;
        end
      end else if (r_state == S_FIX) begin
        r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: ALUControl decode, HI/LO registers and MDU accept/stall/flush gating
module alu_ctrl_mdu
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_mdu_if.slave io_bus
);
  logic             w_rtype, w_md, w_go, w_start, w_wr, w_busy, w_ill;
  logic [3:0]       w_code;
  logic [WIDTH-1:0] r_hi, r_lo, w_res_hi, w_res_lo;
  assign w_rtype  = io_bus.ALUOp == OP_R;
  assign w_md     = w_rtype & is_md(io_bus.funct);
  assign w_go     = io_bus.valid_in & ~io_bus.flush & ~io_bus.stall;
  assign w_start  = w_go & w_md & io_bus.funct[3];
  assign io_bus.stall      = io_bus.valid_in & w_busy & w_md;
  assign io_bus.busy       = w_busy;
  assign io_bus.ALUControl = w_code;
  assign io_bus.illegal    = w_ill;
  assign io_bus.md_rdata   = (w_rtype && io_bus.funct == F_MFHI) ? r_hi
                           : (w_rtype && io_bus.funct == F_MFLO) ? r_lo : '0;
  always_comb begin
    w_code = C_AND;
    w_ill  = 1'b0;
    case (io_bus.ALUOp)
      OP_MEM:  w_code = C_ADD;
      OP_BEQ:  w_code = C_SUB;
      OP_ORI:  w_code = C_OR;
      default:
        case (io_bus.funct)
          F_ADD, F_ADDU:                           w_code = C_ADD;
          F_SUB, F_SUBU:                           w_code = C_SUB;
          F_AND:                                   w_code = C_AND;
          F_OR:                                    w_code = C_OR;
          F_XOR:                                   w_code = C_XOR;
          F_NOR:                                   w_code = C_NOR;
          F_SLT:                                   w_code = C_SLT;
          F_SLTU:                                  w_code = C_SLTU;
          F_SLL:                                   w_code = C_SLL;
          F_SRL:                                   w_code = C_SRL;
          F_SRA:                                   w_code = C_SRA;
          F_MFHI, F_MFLO:                          w_code = C_MDRD;
          F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: w_code = C_NOP;
          default:                                 w_ill  = 1'b1;
        endcase
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_wr) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (w_go && w_rtype && io_bus.funct == F_MTHI) begin
      r_hi <= io_bus.src_a;
    end else if (w_go && w_rtype && io_bus.funct == F_MTLO) begin
      r_lo <= io_bus.src_a;
    end
  end
  alu_ctrl_mdu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(w_start),
    .i_abort(io_bus.flush),
    .i_div  (io_bus.funct[1]),
    .i_sgn  (~io_bus.funct[0]),
    .i_a    (io_bus.src_a),
    .i_b    (io_bus.src_b),
    .o_busy (w_busy),
    .o_done (io_bus.done),
    .o_wr   (w_wr),
    .o_hi   (w_res_hi),
    .o_lo   (w_res_lo)
  );
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: directed self-checking bench for ALU control decode and the MDU
module tb_alu_ctrl_mdu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n;
  int   k;
  logic [31:0] hi, lo;
  logic [5:0] fv [0:20] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                            6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                            6'b000011, 6'b010000, 6'b010010, 6'b010001, 6'b010011, 6'b011000,
                            6'b011001, 6'b011010, 6'b011011};
  logic [3:0] cv [0:20] = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0, 4'h1, 4'h3, 4'h4, 4'h7, 4'hA, 4'h5,
                            4'h8, 4'h9, 4'hB, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  alu_ctrl_mdu_if #(.WIDTH(32)) bus ();
  alu_ctrl_mdu dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic md_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int cnt);
    @(negedge clk);
    bus.valid_in = 1'b1; bus.ALUOp = 2'b10; bus.funct = f; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    bus.valid_in = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic rd(output logic [31:0] h, output logic [31:0] l);
    bus.ALUOp = 2'b10;
    bus.funct = 6'b010000; #1 h = bus.md_rdata;
    bus.funct = 6'b010010; #1 l = bus.md_rdata;
  endtask

  initial begin
    bus.valid_in = 1'b0; bus.flush = 1'b0; bus.ALUOp = 2'b00; bus.funct = '0;
    bus.src_a = '0; bus.src_b = '0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rd(hi, lo);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst_n = 1'b1;
    // decode table, valid_in low so nothing is executed
    bus.ALUOp = 2'b00; #1 chk("dec_lwsw", bus.ALUControl, 4'h2);
    bus.ALUOp = 2'b01; #1 chk("dec_beq", bus.ALUControl, 4'h6);
    bus.ALUOp = 2'b11; #1 chk("dec_ori", bus.ALUControl, 4'h1);
    bus.ALUOp = 2'b10;
    for (int i = 0; i < 21; i++) begin
      bus.funct = fv[i];
      #1 chk($sformatf("dec_%b", fv[i]), bus.ALUControl, cv[i]);
      chk($sformatf("ill_%b", fv[i]), bus.illegal, 0);
    end
    bus.funct = 6'b111111;
    #1 chk("dec_111111", bus.ALUControl, 4'h0);
    chk("ill_111111", bus.illegal, 1);
    // multu max*max
    md_op(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    chk("multu_lat", n, 33);
    chk("multu_done", bus.done, 1);
    rd(hi, lo);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    @(negedge clk);
    chk("multu_done_pulse", bus.done, 0);
    md_op(6'b011000, 32'hFFFFFFFD, 32'd5, n);
    rd(hi, lo);
    chk("mult_neg_hi", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo", lo, 32'hFFFFFFF1);
    md_op(6'b011010, 32'hFFFFFFF9, 32'd2, n);
    rd(hi, lo);
    chk("div_m7_hi", hi, 32'hFFFFFFFF);
    chk("div_m7_lo", lo, 32'hFFFFFFFD);
    md_op(6'b011010, 32'h80000000, 32'hFFFFFFFF, n);
    rd(hi, lo);
    chk("div_min_hi", hi, 0);
    chk("div_min_lo", lo, 32'h80000000);
    md_op(6'b011011, 32'd5, 32'd0, n);
    chk("divu0_lat", n, 33);
    rd(hi, lo);
    chk("divu0_hi", hi, 5);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    md_op(6'b011011, 32'd100, 32'd7, n);
    rd(hi, lo);
    chk("divu_hi", hi, 2);
    chk("divu_lo", lo, 14);
    // mthi / mtlo
    @(negedge clk);
    bus.valid_in = 1'b1; bus.funct = 6'b010001; bus.src_a = 32'h12345678;
    @(negedge clk);
    bus.funct = 6'b010011; bus.src_a = 32'h9ABCDEF0;
    @(negedge clk);
    bus.valid_in = 1'b0;
    rd(hi, lo);
    chk("mthi", hi, 32'h12345678);
    chk("mtlo", lo, 32'h9ABCDEF0);
    // mflo issued while mult in flight stalls until busy drops
    @(negedge clk);
    bus.valid_in = 1'b1; bus.funct = 6'b011000; bus.src_a = 32'd6; bus.src_b = 32'd7;
    @(negedge clk);
    bus.valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.valid_in = 1'b1; bus.funct = 6'b010010;
    #1 chk("stall_mflo", bus.stall, 1);
    bus.funct = 6'b100000;
    #1 chk("stall_add", bus.stall, 0);
    bus.funct = 6'b010010;
    k = 0;
    #1;
    while (bus.stall === 1'b1 && k < 100) begin
      @(negedge clk);
      #1 k++;
    end
    chk("stall_busy", bus.busy, 0);
    chk("stall_done", bus.done, 1);
    chk("stall_rdata", bus.md_rdata, 32'd42);
    bus.valid_in = 1'b0;
    // flush mid-mult
    @(negedge clk);
    bus.valid_in = 1'b1; bus.funct = 6'b011001; bus.src_a = 32'd3; bus.src_b = 32'd4;
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_pre_busy", bus.busy, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) k++;
    end
    chk("flush_no_done", k, 0);
    rd(hi, lo);
    chk("flush_hi", hi, 0);
    chk("flush_lo", lo, 32'd42);
    // flush blocks accept in the same cycle
    @(negedge clk);
    bus.valid_in = 1'b1; bus.flush = 1'b1; bus.funct = 6'b011001;
    @(negedge clk);
    bus.valid_in = 1'b0; bus.flush = 1'b0;
    chk("flush_block", bus.busy, 0);
    // flush during the FIX cycle
    @(negedge clk);
    bus.valid_in = 1'b1; bus.funct = 6'b011001; bus.src_a = 32'd2; bus.src_b = 32'd3;
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (32) @(negedge clk);
    chk("fix_busy", bus.busy, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fix_flush_busy", bus.busy, 0);
    chk("fix_flush_done", bus.done, 0);
    rd(hi, lo);
    chk("fix_flush_lo", lo, 32'd42);
    // async reset mid-div
    @(negedge clk);
    bus.valid_in = 1'b1; bus.funct = 6'b011011; bus.src_a = 32'd100; bus.src_b = 32'd7;
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_busy", bus.busy, 0);
    rd(hi, lo);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    rd(hi, lo);
    chk("rst_after_lo", lo, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
